// File: rtl/video_timing_pkg.sv
// Shared timing constants, sync polarity type and helpers for video_timing_gen.
package video_timing_pkg;

  // Default VGA 640x480@60 raster (25.175 MHz pixel clock)
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Pin level for a sync window flag under the given polarity.
  function automatic logic sync_level(input sync_pol_e pol, input logic active);
    return (pol == ACTIVE_HIGH) ? active : ~active;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis_counter: one raster axis -- wrap counter with display and sync window compares.
module timing_axis_counter #(
  parameter int CNT_W      = 10,
  parameter int TOTAL      = 800,
  parameter int DISPLAY    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] pos,
  output logic             last,
  output logic             in_display,
  output logic             in_sync
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
    end else if (advance) begin
      pos <= last ? '0 : pos + 1'b1;
    end
  end

  // Compares in int so a sync window ending exactly at 2^CNT_W cannot overflow.
  assign last       = (pos == CNT_W'(TOTAL - 1));
  assign in_display = (int'(pos) < DISPLAY);
  assign in_sync    = (int'(pos) >= SYNC_START) && (int'(pos) < SYNC_START + SYNC_LEN);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: prescaled raster timing with registered sync, visible-area and event strobes.
// Define VIDEO_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_count is tied to 0.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int        H_DISPLAY  = VGA_H_DISPLAY,
  parameter int        H_FRONT    = VGA_H_FRONT,
  parameter int        H_SYNC     = VGA_H_SYNC,
  parameter int        H_BACK     = VGA_H_BACK,
  parameter int        V_DISPLAY  = VGA_V_DISPLAY,
  parameter int        V_FRONT    = VGA_V_FRONT,
  parameter int        V_SYNC     = VGA_V_SYNC,
  parameter int        V_BACK     = VGA_V_BACK,
  parameter sync_pol_e H_SYNC_POL = ACTIVE_LOW,
  parameter sync_pol_e V_SYNC_POL = ACTIVE_LOW,
  parameter int        CNT_W      = 10,
  parameter int        PIX_DIV    = 1,
  parameter int        FC_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] screen_hpos,
  output logic [CNT_W-1:0] screen_vpos,
  output logic             pix_stb,
  output logic             line_start,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_end,
  output logic [FC_W-1:0]  frame_count
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if ((1 << CNT_W) < max_int(H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
    $error("video_timing_gen: CNT_W=%0d cannot hold totals %0d x %0d", CNT_W, H_TOTAL, V_TOTAL);
  end
  if (PIX_DIV < 1) begin : g_bad_pix_div
    $error("video_timing_gen: PIX_DIV=%0d must be at least 1", PIX_DIV);
  end

  // Pixel tick prescaler
  logic tick;

  if (PIX_DIV == 1) begin : g_no_div
    assign tick = enable;
  end else begin : g_div
    localparam int DIV_W = $clog2(PIX_DIV);
    logic [DIV_W-1:0] div_cnt;
    logic             div_last;

    assign div_last = (div_cnt == DIV_W'(PIX_DIV - 1));
    assign tick     = enable && div_last;

    always_ff @(posedge clk) begin
      if (reset) begin
        div_cnt <= '0;
      end else if (enable) begin
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      end
    end
  end

  // Axis counters; the vertical axis steps on the horizontal wrap
  logic [CNT_W-1:0] h_pos, v_pos;
  logic             h_last, h_in_disp, h_in_sync;
  logic             v_last, v_in_disp, v_in_sync;
  logic             h_wrap;

  assign h_wrap = tick && h_last;

  timing_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (H_TOTAL),
    .DISPLAY    (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (tick),
    .pos        (h_pos),
    .last       (h_last),
    .in_display (h_in_disp),
    .in_sync    (h_in_sync)
  );

  timing_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (V_TOTAL),
    .DISPLAY    (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (h_wrap),
    .pos        (v_pos),
    .last       (v_last),
    .in_display (v_in_disp),
    .in_sync    (v_in_sync)
  );

  // A position earns its strobes once, on the first decode after the tick
  // (or reset) that entered it, and only while enabled.
  logic tick_q, reset_q;
  logic pos_new, visible, h_zero, h_disp_end;

  assign pos_new    = enable && (tick_q || reset_q);
  assign visible    = h_in_disp && v_in_disp;
  assign h_zero     = (h_pos == '0);
  assign h_disp_end = (h_pos == CNT_W'(H_DISPLAY));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= 1'b0;
      reset_q     <= 1'b1;
      hsync       <= sync_level(H_SYNC_POL, 1'b0);
      vsync       <= sync_level(V_SYNC_POL, 1'b0);
      display_on  <= 1'b0;
      screen_hpos <= '0;
      screen_vpos <= '0;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      tick_q      <= tick;
      reset_q     <= 1'b0;
      hsync       <= sync_level(H_SYNC_POL, h_in_sync);
      vsync       <= sync_level(V_SYNC_POL, v_in_sync);
      display_on  <= visible;
      screen_hpos <= visible ? h_pos : '0;
      screen_vpos <= visible ? v_pos : '0;
      pix_stb     <= enable && tick_q;
      line_start  <= pos_new && h_zero && v_in_disp;
      line_end    <= pos_new && h_disp_end && v_in_disp;
      frame_start <= pos_new && h_zero && (v_pos == '0);
      frame_end   <= pos_new && h_disp_end && (v_pos == CNT_W'(V_DISPLAY));
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [FC_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (h_wrap && v_last) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign frame_count = frame_cnt;
`else
  logic unused_v_last;
  assign unused_v_last = v_last;
  assign frame_count   = '0;
`endif

endmodule
